// File: rtl/vga_raster_gen.sv
// Raster/timing generator for a 640x480@60 VGA path: row/col counters, sync and blank
// generation, and a sync delay line that keeps the pins aligned with the filter latency.
module vga_raster_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_LAT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  output logic [12:0] row,
  output logic [12:0] col,
  output logic        active,
  output logic        line_start,
  output logic        frame_start,
  input  logic [7:0]  in_R,
  input  logic [7:0]  in_G,
  input  logic [7:0]  in_B,
  output logic [7:0]  o_VGA_R,
  output logic [7:0]  o_VGA_G,
  output logic [7:0]  o_VGA_B,
  output logic        o_hsync_n,
  output logic        o_vsync_n,
  output logic        o_blank_n
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [12:0] H_LAST   = 13'(H_TOTAL - 1);
  localparam logic [12:0] V_LAST   = 13'(V_TOTAL - 1);
  localparam logic [12:0] H_VIS    = 13'(H_ACTIVE);
  localparam logic [12:0] V_VIS    = 13'(V_ACTIVE);
  localparam logic [12:0] HS_START = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] VS_START = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic act;
  } tmg_t;

  localparam tmg_t TMG_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, act: 1'b0};

  logic [12:0] col_r;
  logic [12:0] row_r;
  tmg_t        raw_s;
  tmg_t        dly_s;

  // Raster counters: col wraps at the line end and carries into row
  always_ff @(posedge clk) begin
    if (reset) begin
      col_r <= 13'd0;
      row_r <= 13'd0;
    end else if (pix_en) begin
      if (col_r == H_LAST) begin
        col_r <= 13'd0;
        if (row_r == V_LAST) begin
          row_r <= 13'd0;
        end else begin
          row_r <= row_r + 13'd1;
        end
      end else begin
        col_r <= col_r + 13'd1;
      end
    end
  end

  assign row         = row_r;
  assign col         = col_r;
  assign active      = (col_r < H_VIS) && (row_r < V_VIS);
  assign line_start  = (col_r == 13'd0);
  assign frame_start = (col_r == 13'd0) && (row_r == 13'd0);

  // Undelayed timing for the coordinate currently on row/col
  always_comb begin
    raw_s      = TMG_IDLE;
    raw_s.hs_n = !((col_r >= HS_START) && (col_r < HS_END));
    raw_s.vs_n = !((row_r >= VS_START) && (row_r < VS_END));
    raw_s.act  = active;
  end

  generate
    if (PIPE_LAT == 0) begin : g_no_dly
      assign dly_s = raw_s;
    end else begin : g_dly
      tmg_t stage_r [PIPE_LAT];

      // Timing shift register matching the filter pipeline depth
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < PIPE_LAT; i++) begin
            stage_r[i] <= TMG_IDLE;
          end
        end else if (pix_en) begin
          stage_r[0] <= raw_s;
          for (int i = 1; i < PIPE_LAT; i++) begin
            stage_r[i] <= stage_r[i-1];
          end
        end
      end

      assign dly_s = stage_r[PIPE_LAT-1];
    end
  endgenerate

  // Pin register; pixel data is forced to black outside the visible window
  always_ff @(posedge clk) begin
    if (reset) begin
      o_hsync_n <= 1'b1;
      o_vsync_n <= 1'b1;
      o_blank_n <= 1'b0;
      o_VGA_R   <= 8'h00;
      o_VGA_G   <= 8'h00;
      o_VGA_B   <= 8'h00;
    end else if (pix_en) begin
      o_hsync_n <= dly_s.hs_n;
      o_vsync_n <= dly_s.vs_n;
      o_blank_n <= dly_s.act;
      if (dly_s.act) begin
        o_VGA_R <= in_R;
        o_VGA_G <= in_G;
        o_VGA_B <= in_B;
      end else begin
        o_VGA_R <= 8'h00;
        o_VGA_G <= 8'h00;
        o_VGA_B <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_vga_raster_gen.sv
// Bench for vga_raster_gen: three instances (default timing with latency 0 and 3, and a
// shrunken raster for whole-frame counts) checked every clock against a tick-count model.
module tb_vga_raster_gen;

  localparam int SLAT = 2;
  localparam int SFT  = 28 * 17;

  typedef struct packed {
    logic [12:0] row;
    logic [12:0] col;
    logic        act;
    logic        hs_n;
    logic        vs_n;
  } crd_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_en = 1'b1;

  logic [7:0]  in0_r, in0_g, in0_b, in3_r, in3_g, in3_b, ins_r, ins_g, ins_b;
  logic [12:0] row0, col0, row3, col3, rows, cols;
  logic        act0, ls0, fs0, hs0, vs0, bl0;
  logic        act3, ls3, fs3, hs3, vs3, bl3;
  logic        acts, lss, fss, hss, vss, bls;
  logic [7:0]  r0, g0, b0, r3, g3, b3, rs, gs, bs;

  int total = 0;
  int bad = 0;
  int t = 0;
  bit seen_rst = 1'b0;
  bit done_line = 1'b0;
  bit done_frame = 1'b0;
  int lo0 = 0, lo3 = 0, first0 = 0, first3 = 0;
  int fs_cnt = 0, vs_lo = 0, bl_hi = 0;
  logic [23:0] inh0 [8];
  logic [23:0] inhs [8];
  logic [15:0] h3 [8];

  vga_raster_gen #(.PIPE_LAT(0)) d0 (
    .clk(clk), .reset(reset), .pix_en(pix_en), .row(row0), .col(col0),
    .active(act0), .line_start(ls0), .frame_start(fs0),
    .in_R(in0_r), .in_G(in0_g), .in_B(in0_b),
    .o_VGA_R(r0), .o_VGA_G(g0), .o_VGA_B(b0),
    .o_hsync_n(hs0), .o_vsync_n(vs0), .o_blank_n(bl0)
  );

  vga_raster_gen #(.PIPE_LAT(3)) d3 (
    .clk(clk), .reset(reset), .pix_en(pix_en), .row(row3), .col(col3),
    .active(act3), .line_start(ls3), .frame_start(fs3),
    .in_R(in3_r), .in_G(in3_g), .in_B(in3_b),
    .o_VGA_R(r3), .o_VGA_G(g3), .o_VGA_B(b3),
    .o_hsync_n(hs3), .o_vsync_n(vs3), .o_blank_n(bl3)
  );

  vga_raster_gen #(
    .H_ACTIVE(16), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIPE_LAT(SLAT)
  ) ds (
    .clk(clk), .reset(reset), .pix_en(pix_en), .row(rows), .col(cols),
    .active(acts), .line_start(lss), .frame_start(fss),
    .in_R(ins_r), .in_G(ins_g), .in_B(ins_b),
    .o_VGA_R(rs), .o_VGA_G(gs), .o_VGA_B(bs),
    .o_hsync_n(hss), .o_vsync_n(vss), .o_blank_n(bls)
  );

  always #10 clk = ~clk;

  // Coordinate and raw timing of the k-th pixel tick after reset
  function automatic crd_t at_tick(input int k, input bit sm);
    int ha, hf, hsw, va, vf, vsw, ht, vt, c, r;
    crd_t o;
    ha = sm ? 16 : 640; hf = sm ? 3 : 16; hsw = sm ? 5 : 96;
    va = sm ? 10 : 480; vf = sm ? 2 : 10; vsw = 2;
    ht = sm ? 28 : 800; vt = sm ? 17 : 525;
    c = k % ht;
    r = (k / ht) % vt;
    o.row  = 13'(r);
    o.col  = 13'(c);
    o.act  = (c < ha) && (r < va);
    o.hs_n = !((c >= ha + hf) && (c < ha + hf + hsw));
    o.vs_n = !((r >= va + vf) && (r < va + vf + vsw));
    return o;
  endfunction

  // Everything the DUT should show after t ticks: live counters plus pins lagging lat+1 ticks
  function automatic logic [55:0] expect_vec(input int tt, input int lat, input bit sm,
                                             input bit coord_pix, input logic [23:0] pix);
    crd_t cur, pin;
    int k;
    logic hs, vs, bl;
    logic [23:0] rgb;
    cur = at_tick(tt, sm);
    k = tt - lat - 1;
    hs = 1'b1; vs = 1'b1; bl = 1'b0; rgb = 24'h0;
    if (k >= 0) begin
      pin = at_tick(k, sm);
      hs = pin.hs_n; vs = pin.vs_n; bl = pin.act;
      if (pin.act) rgb = coord_pix ? {pin.row[7:0], pin.col[7:0], 8'h5A} : pix;
    end
    return {cur.row, cur.col, cur.act, cur.col == 13'd0,
            (cur.row == 13'd0) && (cur.col == 13'd0), hs, vs, bl, rgb};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0d got=%h want=%h", nm, t, got, want);
    end
  endtask

  // One clk: drive inputs, update the tick model at the edge, check at the falling edge
  task automatic cycle(input logic rst_v, input logic en_v);
    bit tk;
    logic [23:0] p0, ps;
    reset = rst_v;
    pix_en = en_v;
    {in0_r, in0_g, in0_b} = 24'($urandom);
    {ins_r, ins_g, ins_b} = 24'($urandom);
    if (t >= 3) {in3_r, in3_g, in3_b} = {h3[(t - 3) % 8], 8'h5A};
    else {in3_r, in3_g, in3_b} = 24'($urandom);
    @(posedge clk);
    tk = 1'b0;
    if (rst_v) begin
      t = 0;
      seen_rst = 1'b1;
    end else if (en_v) begin
      inh0[t % 8] = {in0_r, in0_g, in0_b};
      inhs[t % 8] = {ins_r, ins_g, ins_b};
      t++;
      tk = 1'b1;
    end
    @(negedge clk);
    if (seen_rst) begin
      p0 = (t > 0) ? inh0[(t - 1) % 8] : 24'h0;
      ps = (t > 0) ? inhs[(t - 1) % 8] : 24'h0;
      chk("lat0", {8'h0, row0, col0, act0, ls0, fs0, hs0, vs0, bl0, r0, g0, b0},
          {8'h0, expect_vec(t, 0, 1'b0, 1'b0, p0)});
      chk("lat3", {8'h0, row3, col3, act3, ls3, fs3, hs3, vs3, bl3, r3, g3, b3},
          {8'h0, expect_vec(t, 3, 1'b0, 1'b1, 24'h0)});
      chk("small", {8'h0, rows, cols, acts, lss, fss, hss, vss, bls, rs, gs, bs},
          {8'h0, expect_vec(t, SLAT, 1'b1, 1'b0, ps)});
      h3[t % 8] = {row3[7:0], col3[7:0]};
    end
    if (tk && !done_line && t >= 1 && t <= 800) begin
      if (!hs0) begin lo0++; if (first0 == 0) first0 = t; end
      if (!hs3) begin lo3++; if (first3 == 0) first3 = t; end
      if (t == 800) begin
        chk("hsync_low_ticks_lat0", 64'(lo0), 64'd96);
        chk("hsync_low_ticks_lat3", 64'(lo3), 64'd96);
        chk("hsync_first_low_lat0", 64'(first0), 64'd657);
        chk("hsync_first_low_lat3", 64'(first3), 64'd660);
        done_line = 1'b1;
      end
    end
    if (tk && !done_frame) begin
      if (t >= SFT && t < 2 * SFT && fss) fs_cnt++;
      if (t >= SLAT + 1 + SFT && t <= SLAT + 2 * SFT) begin
        if (!vss) vs_lo++;
        if (bls) bl_hi++;
      end
      if (t == SLAT + 2 * SFT) begin
        chk("frame_start_per_frame", 64'(fs_cnt), 64'd1);
        chk("vsync_low_ticks", 64'(vs_lo), 64'd56);
        chk("blank_high_ticks", 64'(bl_hi), 64'd160);
        done_frame = 1'b1;
      end
    end
  endtask

  initial begin
    {in0_r, in0_g, in0_b, in3_r, in3_g, in3_b, ins_r, ins_g, ins_b} = 72'h0;

    // hand-computed points that pin the model to the 640x480 timing
    chk("model_hs_656", 64'(at_tick(656, 1'b0).hs_n), 64'd0);
    chk("model_hs_655", 64'(at_tick(655, 1'b0).hs_n), 64'd1);
    chk("model_hs_752", 64'(at_tick(752, 1'b0).hs_n), 64'd1);
    chk("model_vs_490", 64'(at_tick(490 * 800, 1'b0).vs_n), 64'd0);
    chk("model_vs_492", 64'(at_tick(492 * 800, 1'b0).vs_n), 64'd1);
    chk("model_act_640", 64'(at_tick(640, 1'b0).act), 64'd0);
    chk("model_act_479_639", 64'(at_tick(479 * 800 + 639, 1'b0).act), 64'd1);
    chk("model_act_480", 64'(at_tick(480 * 800, 1'b0).act), 64'd0);
    chk("model_wrap_line", 64'({at_tick(800, 1'b0).row, at_tick(800, 1'b0).col}),
        64'({13'd1, 13'd0}));
    chk("model_wrap_frame", 64'(at_tick(525 * 800, 1'b0).row), 64'd0);

    repeat (3) cycle(1'b1, 1'b1);
    chk("reset_pins", {40'h0, hs0, vs0, bl0, r0, g0, b0}, {40'h0, 3'b110, 24'h0});
    chk("reset_counters", 64'({row0, col0}), 64'd0);

    for (int i = 0; i < 2000; i++) cycle(1'b0, 1'(i % 2));
    for (int i = 0; i < 4000; i++) cycle(1'b0, $urandom_range(3) != 0);
    repeat (50) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'($urandom));
    chk("midreset_counters", 64'({rows, cols, row3, col3}), 64'd0);
    chk("midreset_pins", {40'h0, hs3, vs3, bl3, r3, g3, b3}, {40'h0, 3'b110, 24'h0});
    for (int i = 0; i < 20000; i++) cycle($urandom_range(999) == 0, 1'($urandom_range(1)));
    for (int i = 0; i < 3000; i++) cycle(1'b0, 1'b1);

    chk("line_window_reached", 64'(done_line), 64'd1);
    chk("frame_window_reached", 64'(done_frame), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
